// File: rtl/display_hex.sv
// Responder for the nibble display handshake: renders one hex digit per
// start/done transaction as a 5x5 cell (4x5 glyph + spacer) into a pixel framebuffer.
module display_hex #(
  parameter int chars = 8,
  parameter int xw    = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    display_hex_data_in,
  input  logic          display_hex_start,
  input  logic          clearAll,
  output logic          display_hex_done,
  output logic          fb_we,
  output logic [xw-1:0] fb_x,
  output logic [2:0]    fb_y,
  output logic          fb_pixel,
  output logic          busy
);
  localparam int            CW     = (chars > 1) ? $clog2(chars) : 1;
  localparam logic [xw-1:0] LAST_X = xw'(chars*5 - 1);
  localparam logic [xw-1:0] X5     = xw'(5);
  localparam logic [CW-1:0] LAST_C = CW'(chars - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE, S_CLEAR} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cursor, w_cursor_nx;
  logic [2:0]    r_row, w_row_nx, r_col, w_col_nx;
  logic [3:0]    r_digit, w_digit_nx;
  logic          r_clr_pend, w_pend_nx;
  logic [xw-1:0] r_cx, w_cx_nx;
  logic [2:0]    r_cy, w_cy_nx;
  logic          r_we, w_we_nx, r_done, w_done_nx, r_pix, w_pix_nx, r_busy;
  logic [xw-1:0] r_x, w_x_nx;
  logic [2:0]    r_y, w_y_nx;
  logic [xw-1:0] w_base;

  // Glyph rows are nibbles, top row in the MSBs; within a nibble MSB is leftmost.
  function automatic logic glyph_pix(input logic [3:0] d, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [19:0] g;
    logic [4:0]  idx;
    g = 20'h0;
    case (d)
      4'h0: g = 20'hF999F;  4'h1: g = 20'h26227;
      4'h2: g = 20'hF1F8F;  4'h3: g = 20'hF1F1F;
      4'h4: g = 20'h99F11;  4'h5: g = 20'hF8F1F;
      4'h6: g = 20'hF8F9F;  4'h7: g = 20'hF1111;
      4'h8: g = 20'hF9F9F;  4'h9: g = 20'hF9F1F;
      4'hA: g = 20'hF9F99;  4'hB: g = 20'hE9E9E;
      4'hC: g = 20'hF888F;  4'hD: g = 20'hE999E;
      4'hE: g = 20'hF8F8F;  default: g = 20'hF8F88;
    endcase
    idx = 5'd19 - {row, 2'b00} - {2'b00, col};
    if (col > 3'd3 || row > 3'd4) return 1'b0;
    return g[idx];
  endfunction

  assign w_base = xw'(r_cursor) * X5;

  // Outputs are computed alongside the next state so they leave flops.
  always_comb begin
    w_state_nx  = r_state;
    w_cursor_nx = r_cursor;
    w_row_nx    = r_row;
    w_col_nx    = r_col;
    w_digit_nx  = r_digit;
    w_pend_nx   = r_clr_pend;
    w_cx_nx     = r_cx;
    w_cy_nx     = r_cy;
    w_we_nx     = 1'b0;
    w_done_nx   = 1'b0;
    w_x_nx      = r_x;
    w_y_nx      = r_y;
    w_pix_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clearAll || r_clr_pend) begin
          w_state_nx = S_CLEAR;
          w_pend_nx  = 1'b0;
          w_cx_nx    = '0;
          w_cy_nx    = 3'd0;
          w_we_nx    = 1'b1;
          w_x_nx     = '0;
          w_y_nx     = 3'd0;
        end else if (display_hex_start) begin
          w_state_nx = S_DRAW;
          w_digit_nx = display_hex_data_in;
          w_row_nx   = 3'd0;
          w_col_nx   = 3'd0;
          w_we_nx    = 1'b1;
          w_x_nx     = w_base;
          w_y_nx     = 3'd0;
          w_pix_nx   = glyph_pix(display_hex_data_in, 3'd0, 3'd0);
        end
      end
      S_DRAW: begin
        if (clearAll) w_pend_nx = 1'b1;
        if (r_row == 3'd4 && r_col == 3'd4) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else begin
          if (r_col == 3'd4) begin
            w_col_nx = 3'd0;
            w_row_nx = r_row + 3'd1;
          end else begin
            w_col_nx = r_col + 3'd1;
          end
          w_we_nx  = 1'b1;
          w_x_nx   = w_base + xw'(w_col_nx);
          w_y_nx   = w_row_nx;
          w_pix_nx = glyph_pix(r_digit, w_row_nx, w_col_nx);
        end
      end
      S_DONE: begin
        // Sender still holds start with the old digit here, so never accept.
        if (clearAll) w_pend_nx = 1'b1;
        w_cursor_nx = (r_cursor == LAST_C) ? '0 : r_cursor + CW'(1);
        w_state_nx  = S_IDLE;
      end
      default: begin
        if (r_cx == LAST_X && r_cy == 3'd4) begin
          w_state_nx  = S_IDLE;
          w_cursor_nx = '0;
        end else begin
          if (r_cx == LAST_X) begin
            w_cx_nx = '0;
            w_cy_nx = r_cy + 3'd1;
          end else begin
            w_cx_nx = r_cx + xw'(1);
          end
          w_we_nx = 1'b1;
          w_x_nx  = w_cx_nx;
          w_y_nx  = w_cy_nx;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cursor   <= '0;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_digit    <= 4'h0;
      r_clr_pend <= 1'b0;
      r_cx       <= '0;
      r_cy       <= 3'd0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_y        <= 3'd0;
      r_pix      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cursor   <= w_cursor_nx;
      r_row      <= w_row_nx;
      r_col      <= w_col_nx;
      r_digit    <= w_digit_nx;
      r_clr_pend <= w_pend_nx;
      r_cx       <= w_cx_nx;
      r_cy       <= w_cy_nx;
      r_we       <= w_we_nx;
      r_done     <= w_done_nx;
      r_x        <= w_x_nx;
      r_y        <= w_y_nx;
      r_pix      <= w_pix_nx;
      r_busy     <= (w_state_nx != S_IDLE);
    end
  end

  assign display_hex_done = r_done;
  assign fb_we            = r_we;
  assign fb_x             = r_x;
  assign fb_y             = r_y;
  assign fb_pixel         = r_pix;
  assign busy             = r_busy;
endmodule

// File: tb/tb_display_hex.sv
// Scoreboard bench for display_hex: expected pixel writes are queued as each
// digit or clear is requested and popped as the framebuffer writes appear.
module tb_display_hex;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data  = 4'h0;
  logic       start = 1'b0;
  logic       clr   = 1'b0;
  logic       done, fb_we, fb_pixel, busy;
  logic [5:0] fb_x;
  logic [2:0] fb_y;

  typedef struct {
    logic [5:0] x;
    logic [2:0] y;
    logic       p;
  } wr_t;

  localparam logic [19:0] FONT [16] = '{
    20'hF999F, 20'h26227, 20'hF1F8F, 20'hF1F1F, 20'h99F11, 20'hF8F1F, 20'hF8F9F, 20'hF1111,
    20'hF9F9F, 20'hF9F1F, 20'hF9F99, 20'hE9E9E, 20'hF888F, 20'hE999E, 20'hF8F8F, 20'hF8F88};

  wr_t exp_q[$];
  int  n_cmp    = 0;
  int  n_err    = 0;
  int  n_done   = 0;
  int  m_cursor = 0;

  display_hex #(.chars(8), .xw(6)) dut (
    .clock(clock), .reset(reset), .display_hex_data_in(data), .display_hex_start(start),
    .clearAll(clr), .display_hex_done(done), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
    .fb_pixel(fb_pixel), .busy(busy));

  always #5 clock = ~clock;

  // Advance one cycle and retire any framebuffer write against the scoreboard.
  task automatic tick();
    wr_t e;
    @(posedge clock); #1;
    if (done === 1'b1) n_done++;
    if (fb_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got x=%0d y=%0d p=%0d, expected no write", fb_x, fb_y, fb_pixel);
      end else begin
        e = exp_q.pop_front();
        if (fb_x !== e.x || fb_y !== e.y || fb_pixel !== e.p) begin
          n_err++;
          $display("FAIL pixel_write got (%0d,%0d)=%0d expected (%0d,%0d)=%0d",
                   fb_x, fb_y, fb_pixel, e.x, e.y, e.p);
        end
      end
    end
  endtask

  task automatic push_glyph(input logic [3:0] d);
    wr_t e;
    logic [19:0] g;
    logic [4:0]  idx;
    g = FONT[d];
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        idx = 5'(19 - 4*r - c);
        e.x = 6'(m_cursor*5 + c);
        e.y = 3'(r);
        e.p = (c < 4) ? g[idx] : 1'b0;
        exp_q.push_back(e);
      end
  endtask

  task automatic push_clear();
    wr_t e;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 40; x++) begin
        e.x = 6'(x); e.y = 3'(y); e.p = 1'b0;
        exp_q.push_back(e);
      end
    m_cursor = 0;
  endtask

  // One sender transaction: start held until done, data may change the cycle after.
  task automatic send_digit(input logic [3:0] d, input bit push, input bit pre_clear,
                            input int clr_at, input int exp_t, input bit last);
    int t;
    if (pre_clear) push_clear();
    if (push) push_glyph(d);
    data = d; start = 1'b1; t = 0;
    do begin
      clr = (clr_at == t + 1);
      tick();
      t++;
    end while (done !== 1'b1 && t < exp_t + 10);
    clr = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || t != exp_t) begin
      n_err++;
      $display("FAIL done_latency digit=%h got cycles=%0d done=%b, expected cycles=%0d done=1",
               d, t, done, exp_t);
    end
    m_cursor = (m_cursor + 1) % 8;
    tick();
    if (last) start = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_width got done=%b one cycle after pulse, expected 0", done);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; clr = 1'b0; data = 4'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    m_cursor = 0;
  endtask

  task automatic check_drained(input string name);
    repeat (6) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained got %0d writes outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({done, fb_we, fb_x, fb_y, fb_pixel, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs got done=%b we=%b x=%0d y=%0d p=%b busy=%b, expected all 0",
               done, fb_we, fb_x, fb_y, fb_pixel, busy);
    end
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || fb_we !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got busy=%b we=%b, expected 0 0", busy, fb_we);
    end
  endtask

  task automatic test_single();
    int lx[8] = '{2, 1, 2, 2, 2, 1, 2, 3};
    int ly[8] = '{0, 1, 1, 2, 3, 4, 4, 4};
    logic [24:0] lit;
    wr_t e;
    do_reset();
    lit = '0;
    for (int i = 0; i < 8; i++) lit[ly[i]*5 + lx[i]] = 1'b1;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        e.x = 6'(x); e.y = 3'(y); e.p = lit[y*5 + x];
        exp_q.push_back(e);
      end
    send_digit(4'h1, 1'b0, 1'b0, 0, 26, 1'b1);
    check_drained("single");
    // Cursor must now sit at cell 1.
    send_digit(4'h8, 1'b1, 1'b0, 0, 26, 1'b1);
    check_drained("single_cursor");
  endtask

  task automatic test_sender();
    logic [3:0] ds[4] = '{4'hA, 4'h3, 4'hF, 4'h0};
    do_reset();
    for (int i = 0; i < 4; i++) send_digit(ds[i], 1'b1, 1'b0, 0, 26, i == 3);
    check_drained("sender");
  endtask

  task automatic test_wrap();
    logic [3:0] ds[9] = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hB, 4'hC, 4'hD, 4'hE, 4'h9};
    do_reset();
    for (int i = 0; i < 9; i++) send_digit(ds[i], 1'b1, 1'b0, 0, 26, i == 8);
    check_drained("wrap");
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) send_digit(4'(i), 1'b1, 1'b0, 0, 26, i == 4);
    repeat (2) tick();
    // Clear pulse with start already held: clear first, digit lands in cell 0.
    send_digit(4'h7, 1'b1, 1'b1, 1, 227, 1'b1);
    check_drained("clear");
  endtask

  task automatic test_clear_draw();
    do_reset();
    send_digit(4'h5, 1'b1, 1'b0, 11, 26, 1'b0);
    send_digit(4'h9, 1'b1, 1'b1, 0, 227, 1'b1);
    check_drained("clear_draw");
  endtask

  task automatic test_reset_mid();
    int d0;
    do_reset();
    send_digit(4'h6, 1'b1, 1'b0, 0, 26, 1'b0);
    push_glyph(4'hD);
    data = 4'hD;
    repeat (12) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({done, fb_we, fb_x, fb_y, fb_pixel, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got done=%b we=%b x=%0d y=%0d p=%b busy=%b, expected all 0",
               done, fb_we, fb_x, fb_y, fb_pixel, busy);
    end
    exp_q.delete();
    start = 1'b0;
    m_cursor = 0;
    @(posedge clock);
    #1 reset = 1'b0;
    d0 = n_done;
    repeat (30) tick();
    n_cmp++;
    if (n_done != d0) begin
      n_err++;
      $display("FAIL reset_mid_done got %0d done pulses after reset, expected 0", n_done - d0);
    end
    send_digit(4'hC, 1'b1, 1'b0, 0, 26, 1'b1);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_sender();
    test_wrap();
    test_clear();
    test_clear_draw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
